// File: rtl/adc0809_emu_if.sv
// ADC0809 pin-level handshake bundle between the on-chip controller (master)
// and the converter responder (slave).
interface adc0809_emu_if;
  logic       ale;
  logic       start;
  logic       oe;
  logic [2:0] addr;
  logic       eoc;
  logic [7:0] dout;
  logic       dout_en;

  modport master (output ale, start, oe, addr, input eoc, dout, dout_en);
  modport slave  (input ale, start, oe, addr, output eoc, dout, dout_en);
endinterface

// File: rtl/adc0809_emu.sv
// ADC0809 converter responder: address latch, SAR reset delay, conversion timing,
// EOC handshake and output-enable bus, fed from 8 fabric channel bytes.
module adc0809_emu #(
  parameter int EOC_DELAY   = 8,
  parameter int CONV_CYCLES = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  adc0809_emu_if.slave      bus,
  input  logic [63:0]       ch_data_i,
  output logic [CNT_W-1:0]  conv_cnt_o,
  output logic [CNT_W-1:0]  abort_cnt_o,
  output logic              miss_o
);
  localparam int MAXC = (EOC_DELAY > CONV_CYCLES) ? EOC_DELAY : CONV_CYCLES;
  localparam int DW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, SAR_RST, CONV, DONE} state_t;

  // Per pin {delay, stage2, stage1}; index 0=ale, 1=start, 2=oe.
  logic [2:0][2:0] sync_q;
  logic [2:0]      pins, rise, fall;

  assign pins = {bus.oe, bus.start, bus.ale};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else for (int i = 0; i < 3; i++) sync_q[i] <= {sync_q[i][1:0], pins[i]};
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rise[i] = sync_q[i][1] & ~sync_q[i][2];
      fall[i] = ~sync_q[i][1] & sync_q[i][2];
    end
  end

  logic oe_q;
  assign oe_q = sync_q[2][1];

  state_t           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             eoc_q, eoc_d;
  logic [7:0]       shadow_q, shadow_d, result_q, result_d;
  logic [2:0]       addr_l_q, addr_l_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d, abort_cnt_q, abort_cnt_d;
  logic             miss_q, miss_d, read_q, read_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      eoc_q       <= 1'b1;
      shadow_q    <= '0;
      result_q    <= '0;
      addr_l_q    <= '0;
      conv_cnt_q  <= '0;
      abort_cnt_q <= '0;
      miss_q      <= 1'b0;
      read_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eoc_q       <= eoc_d;
      shadow_q    <= shadow_d;
      result_q    <= result_d;
      addr_l_q    <= addr_l_d;
      conv_cnt_q  <= conv_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      miss_q      <= miss_d;
      read_q      <= read_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    eoc_d       = eoc_q;
    shadow_d    = shadow_q;
    result_d    = result_q;
    addr_l_d    = addr_l_q;
    conv_cnt_d  = conv_cnt_q;
    abort_cnt_d = abort_cnt_q;
    miss_d      = miss_q;
    read_d      = read_q;

    if (rise[0]) addr_l_d = bus.addr;
    if (oe_q)    read_d   = 1'b1;

    unique case (state_q)
      IDLE, DONE: begin
        eoc_d = 1'b1;
        if (rise[1]) begin
          state_d = SAR_RST;
          cnt_d   = DW'(EOC_DELAY);
        end
      end
      SAR_RST: begin
        if (rise[1]) begin
          cnt_d = DW'(EOC_DELAY);
        end else if (fall[1]) begin
          // addr_l_d so a coincident ALE rise selects the new channel
          shadow_d = ch_data_i[{addr_l_d, 3'b000} +: 8];
          cnt_d    = DW'(CONV_CYCLES);
          eoc_d    = 1'b0;
          state_d  = CONV;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) eoc_d = 1'b0;
        end
      end
      CONV: begin
        eoc_d = 1'b0;
        if (rise[1]) begin
          abort_cnt_d = abort_cnt_q + CNT_W'(1);
          cnt_d       = DW'(EOC_DELAY);
          state_d     = SAR_RST;
        end else if (cnt_q <= DW'(1)) begin
          // Completion wins over a same-cycle OE so the new result counts as unread
          result_d   = shadow_q;
          eoc_d      = 1'b1;
          conv_cnt_d = conv_cnt_q + CNT_W'(1);
          if (!read_q) miss_d = 1'b1;
          read_d     = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.eoc     = eoc_q;
  assign bus.dout    = oe_q ? result_q : 8'h00;
  assign bus.dout_en = oe_q;
  assign conv_cnt_o  = conv_cnt_q;
  assign abort_cnt_o = abort_cnt_q;
  assign miss_o      = miss_q;
endmodule

// File: tb/tb_adc0809_emu.sv
// Bench for adc0809_emu: drives the controller side of the handshake, predicts
// results through a scoreboard, and checks timing, counters, miss and reset.
module tb_adc0809_emu;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc0809_emu_if bus();
  logic [63:0]   ch_data;
  logic [CW-1:0] conv_cnt, abort_cnt;
  logic          miss;

  adc0809_emu #(.EOC_DELAY(8), .CONV_CYCLES(64), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .ch_data_i(ch_data),
    .conv_cnt_o(conv_cnt), .abort_cnt_o(abort_cnt), .miss_o(miss)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // eoc edge monitor, sampled on the falling clock edge
  logic eoc_p = 1'b1;
  int   t_fall = 0, t_rise = 0, n_rise = 0;
  always @(negedge clk) begin
    if (eoc_p && !bus.eoc) t_fall = cyc;
    if (!eoc_p && bus.eoc) begin t_rise = cyc; n_rise++; end
    eoc_p = bus.eoc;
  end

  logic [7:0]    sb[$];
  logic [7:0]    last_res = 8'h00;
  logic [CW-1:0] e_conv = '0, e_abort = '0;
  logic          e_miss = 1'b0, e_read = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic oe_read(input string tag);
    bus.oe = 1'b1;
    tick(4);
    @(negedge clk);
    chk({tag, "_en"}, bus.dout_en, 1);
    chk(tag, bus.dout, last_res);
    e_read = 1'b1;
    bus.oe = 1'b0;
    tick(4);
  endtask

  task automatic wait_eoc_rise(input string tag);
    int k = 0;
    while (!bus.eoc && k < 300) begin @(negedge clk); k++; end
    chk({tag, "_timeout"}, k < 300, 1);
    tick(1);
  endtask

  // Model of a completed conversion: pop the prediction, update counters
  task automatic complete(input string tag);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) last_res = sb.pop_front();
    e_conv++;
    if (!e_read) e_miss = 1'b1;
    e_read = 1'b0;
    chk({tag, "_conv_cnt"}, conv_cnt, e_conv);
    chk({tag, "_miss"}, miss, e_miss);
  endtask

  task automatic latch_addr(input logic [2:0] a);
    bus.addr = a; bus.ale = 1'b1; tick(4);
    bus.ale = 1'b0; tick(4);
  endtask

  // hi must be >= 12 so eoc falls while START is still high
  task automatic do_conv(input logic [2:0] a, input int hi, input bit rd, input bit mut);
    int c0, c1;
    logic [7:0] v;
    latch_addr(a);
    bus.start = 1'b1; c0 = cyc;
    tick(hi);
    bus.start = 1'b0; c1 = cyc;
    v = ch_data[int'(a)*8 +: 8];
    sb.push_back(v);
    if (mut) begin tick(5); ch_data[int'(a)*8 +: 8] = ~v; end
    wait_eoc_rise("conv");
    chk("eoc_fall_dly", t_fall - c0, 11);
    chk("eoc_rise_dly", t_rise - c1, 67);
    complete("conv");
    if (rd) oe_read("dout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c1, r0;
    bus.ale = 1'b0; bus.start = 1'b0; bus.oe = 1'b0; bus.addr = 3'd0;
    ch_data = '0;
    tick(2);
    chk("rst_eoc", bus.eoc, 1);
    chk("rst_dout_en", bus.dout_en, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_conv_cnt", conv_cnt, 0);
    chk("rst_miss", miss, 0);
    rst = 1'b1;
    tick(4);

    // basic conversion, channel 2
    ch_data[23:16] = 8'hA5;
    do_conv(3'd2, 57, 1, 0);

    // sweep all channels
    for (int n = 0; n < 8; n++) ch_data[n*8 +: 8] = 8'(8'h10 * n);
    for (int n = 0; n < 8; n++) do_conv(3'(n), 57, 1, 0);

    // input change after START fall must not leak into the result
    ch_data[31:24] = 8'h3C;
    do_conv(3'd3, 20, 1, 1);

    // abort mid-conversion
    ch_data[47:40] = 8'h5A;
    latch_addr(3'd5);
    bus.start = 1'b1; tick(15);
    bus.start = 1'b0;
    sb.push_back(ch_data[47:40]);
    tick(23);
    r0 = n_rise;
    bus.start = 1'b1;
    void'(sb.pop_back());
    e_abort++;
    tick(4);
    chk("abort_cnt", abort_cnt, e_abort);
    chk("abort_eoc_low", bus.eoc, 0);
    ch_data[47:40] = 8'hC3;
    tick(12);
    bus.start = 1'b0; c1 = cyc;
    sb.push_back(ch_data[47:40]);
    wait_eoc_rise("abort");
    chk("abort_rises", n_rise - r0, 1);
    chk("abort_rise_dly", t_rise - c1, 67);
    complete("abort");
    oe_read("abort_dout");

    // two unread conversions -> sticky miss
    ch_data[15:8] = 8'h11; ch_data[55:48] = 8'h66;
    do_conv(3'd1, 20, 0, 0);
    do_conv(3'd6, 20, 0, 0);
    oe_read("miss_dout");
    chk("miss_sticky", miss, 1);

    // reset in the middle of a conversion, with OE showing the previous result
    latch_addr(3'd0);
    bus.start = 1'b1; tick(15);
    bus.start = 1'b0; tick(35);
    bus.oe = 1'b1; tick(4);
    chk("oe_during_conv", bus.dout, last_res);
    rst = 1'b0;
    #1;
    chk("mid_rst_eoc", bus.eoc, 1);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_dout_en", bus.dout_en, 0);
    chk("mid_rst_conv_cnt", conv_cnt, 0);
    chk("mid_rst_abort_cnt", abort_cnt, 0);
    chk("mid_rst_miss", miss, 0);
    e_conv = '0; e_abort = '0; e_miss = 1'b0; e_read = 1'b1; last_res = 8'h00;
    sb.delete();
    bus.oe = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);

    // 16 conversions wrap the 4-bit counter back to zero
    for (int n = 0; n < 16; n++) do_conv(3'(n % 8), 14, 1, 0);
    chk("conv_cnt_wrap", conv_cnt, 0);
    chk("wrap_miss", miss, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
